life_board_loader: RTL



---
 rtl/life_board_loader.sv | 109 ++++++++++
 1 files changed

// File: rtl/life_board_loader.sv
// Control-side driver for a ROWS x COLS life-cell array: serial pattern load,
// then free-running or single-stepped generation strobes.
module life_board_loader #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int PW   = 24,
  parameter int GW   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_start,
  input  logic                 bit_valid,
  input  logic                 bit_data,
  output logic                 bit_ready,
  input  logic                 run,
  input  logic                 step,
  input  logic [PW-1:0]        period,
  output logic [ROWS*COLS-1:0] write_en,
  output logic                 set,
  output logic                 prog,
  output logic                 load_done,
  output logic                 busy,
  output logic [GW-1:0]        gen_count
);
  localparam int N  = ROWS * COLS;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t         state;
  logic [IW-1:0]  idx;
  logic [PW-1:0]  pcnt;
  logic [PW-1:0]  plim;
  logic           accept;

  // Period 0 behaves like period 1.
  assign plim   = (period == '0) ? '0 : period - PW'(1);
  assign accept = bit_valid & bit_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      pcnt      <= '0;
      write_en  <= '0;
      set       <= 1'b0;
      prog      <= 1'b0;
      bit_ready <= 1'b0;
      load_done <= 1'b0;
      busy      <= 1'b0;
      gen_count <= '0;
    end else begin
      write_en  <= '0;
      set       <= 1'b0;
      prog      <= 1'b0;
      load_done <= 1'b0;
      case (state)
        IDLE: begin
          if (load_start) begin
            state     <= LOAD;
            idx       <= '0;
            gen_count <= '0;
            bit_ready <= 1'b1;
            busy      <= 1'b1;
          end else if (run) begin
            state <= RUN;
            pcnt  <= '0;
            busy  <= 1'b1;
          end else if (step) begin
            prog      <= 1'b1;
            gen_count <= gen_count + GW'(1);
          end
        end
        LOAD: begin
          if (accept) begin
            write_en <= {{(N-1){1'b0}}, 1'b1} << idx;
            set      <= bit_data;
            idx      <= idx + IW'(1);
            if (idx == IW'(N - 1)) begin
              state     <= IDLE;
              idx       <= '0;
              bit_ready <= 1'b0;
              busy      <= 1'b0;
              load_done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (!run) begin
            state <= IDLE;
            pcnt  <= '0;
            busy  <= 1'b0;
          end else if (pcnt == plim) begin
            pcnt      <= '0;
            prog      <= 1'b1;
            gen_count <= gen_count + GW'(1);
          end else begin
            pcnt <= pcnt + PW'(1);
          end
        end
        default: begin
          state     <= IDLE;
          bit_ready <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end
endmodule
